// File: rtl/ddr3_stream_writer.sv
// Packs IN_WIDTH words into APP_DATA_WIDTH beats and issues them as write commands to
// the DDR3 controller user interface, addressing a circular region.

module ddr3_sw_lane #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned LANE     = 0,
  parameter int unsigned KW       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IN_WIDTH-1:0]   din,
  input  logic [KW-1:0]         fill,
  output logic [IN_WIDTH-1:0]   q,
  output logic [IN_WIDTH/8-1:0] mask
);
  logic [IN_WIDTH-1:0] slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  slot <= '0;
    else if (we) slot <= din;
  end

  // Bypass lets the word arriving this cycle join a beat that transfers this cycle.
  assign q    = we ? din : slot;
  assign mask = {(IN_WIDTH/8){KW'(LANE) >= fill}};
endmodule

module ddr3_stream_writer #(
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned APP_DATA_WIDTH = 256,
  parameter int unsigned APP_MASK_WIDTH = 32,
  parameter int unsigned IN_WIDTH       = 32,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned REGION_SIZE    = 1 << 20,
  parameter int unsigned ADDR_STEP      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_calib_complete,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      flush,
  input  logic                      cmd_ready,
  input  logic                      wr_data_rdy,
  output logic [2:0]                cmd,
  output logic                      cmd_en,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic [APP_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_data_en,
  output logic                      wr_data_end,
  output logic [APP_MASK_WIDTH-1:0] wr_data_mask,
  output logic [31:0]               beats_written,
  output logic                      busy
);
  localparam int unsigned NUM_LANES = APP_DATA_WIDTH / IN_WIDTH;
  localparam int unsigned KW        = $clog2(NUM_LANES) + 1;
  localparam logic [ADDR_WIDTH:0] STEP_A = (ADDR_WIDTH+1)'(ADDR_STEP);
  localparam logic [ADDR_WIDTH:0] END_A  = (ADDR_WIDTH+1)'(BASE_ADDR + REGION_SIZE);

  logic [KW-1:0] k, ke, k_nxt;
  logic          flush_pend, fp_nxt, fl_eff;
  logic          hold_valid, hv_nxt;
  logic          accept, xfer, issue;
  logic [ADDR_WIDTH:0] addr_inc;
  logic [NUM_LANES-1:0][IN_WIDTH-1:0]   acc_eff;
  logic [NUM_LANES-1:0][IN_WIDTH/8-1:0] msk_eff;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      ddr3_sw_lane #(.IN_WIDTH(IN_WIDTH), .LANE(i), .KW(KW)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (accept && (k == KW'(i))),
        .din  (s_data),
        .fill (ke),
        .q    (acc_eff[i]),
        .mask (msk_eff[i])
      );
    end
  endgenerate

  assign accept = s_valid & s_ready;
  assign ke     = k + KW'(accept);
  assign fl_eff = flush_pend | flush;
  assign issue  = hold_valid & cmd_ready & wr_data_rdy & init_calib_complete;
  // Transfer evaluates the fill including this cycle's word, so a full beat moves on
  // the cycle its last word arrives and the input never stalls while readies are high.
  assign xfer   = ((ke == KW'(NUM_LANES)) || (fl_eff && (ke != '0))) && (!hold_valid || issue);
  assign k_nxt  = xfer ? '0 : ke;
  assign fp_nxt = !xfer && fl_eff && (ke != '0);
  assign hv_nxt = xfer | (hold_valid & ~issue);

  assign addr_inc    = {1'b0, addr} + STEP_A;
  assign cmd         = 3'b000;
  assign cmd_en      = issue;
  assign wr_data_en  = issue;
  assign wr_data_end = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k             <= '0;
      flush_pend    <= 1'b0;
      hold_valid    <= 1'b0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      addr          <= ADDR_WIDTH'(BASE_ADDR);
      wr_data       <= '0;
      wr_data_mask  <= '1;
      beats_written <= '0;
    end else begin
      k          <= k_nxt;
      flush_pend <= fp_nxt;
      hold_valid <= hv_nxt;
      s_ready    <= init_calib_complete && (k_nxt < KW'(NUM_LANES)) && !fp_nxt;
      busy       <= (k_nxt != '0) || hv_nxt;
      if (xfer) begin
        wr_data      <= acc_eff;
        wr_data_mask <= msk_eff;
      end
      if (issue) begin
        addr          <= (addr_inc == END_A) ? ADDR_WIDTH'(BASE_ADDR) : addr_inc[ADDR_WIDTH-1:0];
        beats_written <= beats_written + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_stream_writer.sv
// Directed bench for ddr3_stream_writer; a second instance with a 24-unit region
// shares the stimulus to exercise address wrap.
module tb_ddr3_stream_writer;
  logic         clk = 0;
  logic         rst_n = 0, calib = 0, s_valid = 0, flush = 0, cmd_ready = 1, wr_data_rdy = 1;
  logic [31:0]  s_data = 0;
  logic         s_ready, cmd_en, wr_data_en, wr_data_end, busy;
  logic [2:0]   cmd;
  logic [28:0]  addr;
  logic [255:0] wr_data;
  logic [31:0]  wr_data_mask, beats_written;
  logic         w_s_ready, w_cmd_en, w_wde, w_wdend, w_busy;
  logic [2:0]   w_cmd;
  logic [28:0]  w_addr;
  logic [255:0] w_wd;
  logic [31:0]  w_mask, w_beats;

  int n_chk = 0, n_fail = 0, strobe_err = 0, stalls = 0;
  logic [28:0]  qa[$];
  logic [255:0] qd[$];
  logic [31:0]  qm[$];
  logic [28:0]  wa[$];

  always #5 clk = ~clk;

  ddr3_stream_writer dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .cmd_ready(cmd_ready), .wr_data_rdy(wr_data_rdy),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .wr_data_en(wr_data_en),
    .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask), .beats_written(beats_written),
    .busy(busy));

  ddr3_stream_writer #(.REGION_SIZE(24)) dut_w (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .s_data(s_data), .s_valid(s_valid),
    .s_ready(w_s_ready), .flush(flush), .cmd_ready(cmd_ready), .wr_data_rdy(wr_data_rdy),
    .cmd(w_cmd), .cmd_en(w_cmd_en), .addr(w_addr), .wr_data(w_wd), .wr_data_en(w_wde),
    .wr_data_end(w_wdend), .wr_data_mask(w_mask), .beats_written(w_beats), .busy(w_busy));

  // Capture issued beats on the falling edge, between input updates and the accepting edge.
  always @(negedge clk) begin
    if (cmd_en !== wr_data_en || wr_data_end !== wr_data_en) strobe_err++;
    if (cmd_en && !calib) strobe_err++;
    if (cmd_en) begin
      qa.push_back(addr);
      qd.push_back(wr_data);
      qm.push_back(wr_data_mask);
    end
    if (w_cmd_en) wa.push_back(w_addr);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] w);
    int t = 0;
    s_data = w; s_valid = 1;
    do begin @(negedge clk); t++; end while (!s_ready && t < 200);
    if (!s_ready) chk("push_timeout", 0, 1);
    if (t > 1) stalls++;
    step();
    s_valid = 0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 100 && qa.size() < n; c++) step();
    chk("beat_count_timeout", qa.size(), n);
  endtask

  function automatic logic [255:0] mk(input logic [31:0] b, input int n);
    logic [255:0] d = '0;
    for (int i = 0; i < n; i++) d[32*i +: 32] = b + i;
    return d;
  endfunction

  initial begin
    logic [255:0] e, g;
    int acc_cnt;
    repeat (3) step();
    // Reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_mask", wr_data_mask, 32'hFFFF_FFFF);
    chk("rst_beats", beats_written, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    // Calibration gate
    s_valid = 1; s_data = 32'hDEAD;
    repeat (4) begin @(negedge clk); chk("calib_s_ready", s_ready, 0); step(); end
    chk("calib_busy", busy, 0);
    s_valid = 0; calib = 1;
    step();
    // Streaming two full beats
    push(32'h1000);
    stalls = 0;
    for (int i = 1; i < 16; i++) push(32'h1000 + i);
    chk("stream_stalls", stalls, 0);
    wait_beats(2);
    step();
    chk("stream_a0", qa[0], 0);
    e = mk(32'h1000, 8); chk("stream_d0", qd[0], e);
    chk("stream_m0", qm[0], 0);
    chk("stream_a1", qa[1], 8);
    e = mk(32'h1008, 8); chk("stream_d1", qd[1], e);
    chk("stream_beats", beats_written, 2);
    // Backpressure: 20 offered, 16 absorbed
    cmd_ready = 0; acc_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      s_data = 32'h2000 + acc_cnt; s_valid = (acc_cnt < 20);
      @(negedge clk);
      if (s_valid && s_ready) acc_cnt++;
      step();
    end
    s_valid = 0;
    chk("bp_accepted", acc_cnt, 16);
    @(negedge clk);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_no_issue", beats_written, 2);
    step();
    cmd_ready = 1;
    @(negedge clk);
    chk("bp_release_strobe", cmd_en, 1);
    chk("bp_release_s_ready", s_ready, 0);
    step();
    @(negedge clk);
    chk("bp_s_ready_rise", s_ready, 1);
    wait_beats(4);
    chk("bp_a2", qa[2], 16);
    e = mk(32'h2000, 8); chk("bp_d2", qd[2], e);
    chk("bp_a3", qa[3], 24);
    e = mk(32'h2008, 8); chk("bp_d3", qd[3], e);
    // Wrap instance saw the same four beats
    chk("wrap_n", wa.size(), 4);
    chk("wrap_a0", wa[0], 0);
    chk("wrap_a1", wa[1], 8);
    chk("wrap_a2", wa[2], 16);
    chk("wrap_a3", wa[3], 0);
    // Flush with nothing buffered is a no-op
    step(); flush = 1; step(); flush = 0;
    repeat (3) step();
    chk("flush_noop_beats", beats_written, 4);
    chk("flush_noop_busy", busy, 0);
    // Flush of a 3-word partial beat
    for (int i = 0; i < 3; i++) push(32'h3000 + i);
    flush = 1; step(); flush = 0;
    wait_beats(5);
    chk("flush_a", qa[4], 32);
    chk("flush_m", qm[4], 32'hFFFF_F000);
    g = qd[4]; e = mk(32'h3000, 3);
    chk("flush_d", g[95:0], e[95:0]);
    for (int i = 0; i < 8; i++) push(32'h4000 + i);
    wait_beats(6);
    chk("post_flush_a", qa[5], 40);
    chk("post_flush_m", qm[5], 0);
    e = mk(32'h4000, 8); chk("post_flush_d", qd[5], e);
    // Reset mid-beat
    for (int i = 0; i < 5; i++) push(32'h5000 + i);
    @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    step(); rst_n = 0; step(); rst_n = 1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_addr", addr, 0);
    chk("mid_beats", beats_written, 0);
    step();
    for (int i = 0; i < 8; i++) push(32'h6000 + i);
    wait_beats(7);
    chk("mid_a", qa[6], 0);
    e = mk(32'h6000, 8); chk("mid_d", qd[6], e);
    chk("mid_m", qm[6], 0);
    step();
    chk("mid_beats_after", beats_written, 1);
    chk("strobe_pairing", strobe_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
